tc_timer: RTL and testbench

- Memory-mapped timer/counter peripheral on the CPU data port, directly downstream of the mips core.
- Consumes the core's M-stage data bus outputs (m_data_addr, m_data_wdata, m_data_byteen).
- Returns read data on the same cycle for the CPU's m_data_rdata mux and raises an interrupt request.
- Internally: three registers plus a 4-state counting FSM.

---
 rtl/tc_timer.sv | 145 ++++++++++++++
 tb/tb_tc_timer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped timer/counter on the CPU data port.
//
// Sixteen-byte register window at BASE_ADDR:
//   offset 0  CTRL    [0] EN, [2:1] MODE (01 auto-reload, else one-shot), [3] IM
//   offset 1  PRESET  32-bit reload value
//   offset 2  COUNT   read-only current count
//   offset 3  reserved, reads 0
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   addr    byte address from the core's M stage
//   wdata   write data from the core's M stage
//   byteen  byte write enables, 4'b0000 means read / no access
//   hit     address falls inside the register window
//   rdata   same-cycle read data, 0 when hit is low
//   irq     interrupt request (latched flag gated by IM)
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | stopped, COUNT held, waiting for EN
// LOAD   | copy PRESET into COUNT
// CNT    | count down once per cycle, leave when EN drops
// INT    | terminal count reached; reload or stop depending on MODE

module tc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        irq_set;
    logic [31:0] preset_merged;
    logic        unused_addr;

    // addr[1:0] only select a byte inside a word and play no role in decode.
    assign unused_addr = &{1'b0, addr[1:0]};

    always_comb begin
        hit       = (addr[31:4] == BASE_ADDR[31:4]);
        wr_en     = hit && (byteen != 4'b0000);
        wr_ctrl   = wr_en && (addr[3:2] == 2'd0);
        wr_preset = wr_en && (addr[3:2] == 2'd1);

        for (int i = 0; i < 4; i++) begin
            preset_merged[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : preset[8*i +: 8];
        end

        // Terminal count is detected while still in CNT; COUNT of 0 or 1 both end the run.
        irq_set = (state == S_CNT) && ctrl[0] && (count <= 32'd1);

        rdata = 32'd0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rdata = {28'd0, ctrl};
                2'd1:    rdata = preset;
                2'd2:    rdata = count;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign irq = irq_flag & ctrl[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count <= 32'd1) begin
                        count <= 32'd0;
                        state <= S_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                S_INT: begin
                    if (ctrl[2:1] == 2'b01) begin
                        state <= S_LOAD;
                    end else begin
                        state   <= S_IDLE;
                        ctrl[0] <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Placed after the FSM so a software CTRL write overrides the
            // hardware EN clear on the same edge. Only lane 0 holds CTRL bits.
            if (wr_ctrl && byteen[0]) begin
                ctrl <= wdata[3:0];
            end
            if (wr_preset) begin
                preset <= preset_merged;
            end

            // A terminal-count set beats a concurrent software clear.
            if (irq_set) begin
                irq_flag <= 1'b1;
            end else if (wr_ctrl || wr_preset) begin
                irq_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tc_timer.sv
module tb_tc_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tc_timer #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .hit    (hit),
        .rdata  (rdata),
        .irq    (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: the timer as "phases" of a run, stepped from the
    // register-level rules. phase: 0 stopped, 1 reload due, 2 counting, 3 expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    function automatic void model_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_flag   = 1'b0;
        m_phase  = 0;
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_hit(a)) return 32'd0;
        case ((a >> 2) & 32'd3)
            32'd0:   return {28'd0, m_ctrl};
            32'd1:   return m_preset;
            32'd2:   return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_clock(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [3:0]  n_ctrl   = m_ctrl;
        logic [31:0] n_preset = m_preset;
        logic [31:0] n_count  = m_count;
        int          n_phase  = m_phase;
        logic        set      = 1'b0;
        logic        write    = model_hit(a) && (be != 0);
        int          off      = int'((a >> 2) & 32'd3);
        logic        en       = m_ctrl[0];

        if (m_phase == 0) begin
            if (en) n_phase = 1;
        end else if (m_phase == 1) begin
            n_count = m_preset;
            n_phase = 2;
        end else if (m_phase == 2) begin
            if (!en) n_phase = 0;
            else if (m_count < 2) begin
                n_count = 0;
                set     = 1'b1;
                n_phase = 3;
            end else n_count = m_count - 1;
        end else begin
            if (m_ctrl[2:1] == 2'b01) n_phase = 1;
            else begin
                n_phase   = 0;
                n_ctrl[0] = 1'b0;
            end
        end

        if (write && off == 0 && be[0]) n_ctrl = d[3:0];
        if (write && off == 1) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) n_preset[8*i +: 8] = d[8*i +: 8];
        end

        if (set) m_flag = 1'b1;
        else if (write && off <= 1) m_flag = 1'b0;

        m_ctrl   = n_ctrl;
        m_preset = n_preset;
        m_count  = n_count;
        m_phase  = n_phase;
    endfunction

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        @(negedge clk);
        chk("hit", {31'd0, hit}, {31'd0, model_hit(addr)});
        chk("rdata", rdata, model_read(addr));
        chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
        @(posedge clk);
        model_clock(addr, wdata, byteen);
        #1;
    endtask

    task automatic bus_idle();
        addr   = BASE;
        wdata  = 32'd0;
        byteen = 4'd0;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
        addr   = BASE + 32'(off * 4);
        wdata  = d;
        byteen = be;
        cycle();
        bus_idle();
    endtask

    task automatic peek(input int off, input logic [31:0] exp, input string tag);
        addr   = BASE + 32'(off * 4);
        byteen = 4'd0;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic run_until_count(input logic [31:0] target, input logic need_flag, input string tag);
        int budget = 60;
        while (!(m_count == target && (m_flag || !need_flag)) && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for count=%0d", tag, target);
        end
    endtask

    logic [31:0] exp_seq [4] = '{32'd2, 32'd1, 32'd0, 32'd0};

    initial begin
        reset = 1'b0;
        bus_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        peek(0, 32'd0, "rst_ctrl");
        peek(1, 32'd0, "rst_preset");
        peek(2, 32'd0, "rst_count");
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // One-shot, PRESET=3.
        wr(1, 32'd3, 4'hF);
        wr(0, 32'h9, 4'hF);
        repeat (2) cycle();
        peek(2, 32'd3, "os_e2");
        cycle(); peek(2, 32'd2, "os_e3");
        cycle(); peek(2, 32'd1, "os_e4");
        chk("os_irq_e4", {31'd0, irq}, 32'd0);
        cycle(); peek(2, 32'd0, "os_e5");
        chk("os_irq_e5", {31'd0, irq}, 32'd1);
        cycle(); peek(0, 32'h8, "os_ctrl_e6");
        repeat (3) cycle();
        chk("os_irq_hold", {31'd0, irq}, 32'd1);
        wr(0, 32'h8, 4'hF);
        chk("os_irq_clr", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=2: period of 4 cycles.
        wr(1, 32'd2, 4'hF);
        wr(0, 32'hB, 4'hF);
        repeat (2) cycle();
        for (int i = 0; i < 8; i++) begin
            peek(2, exp_seq[i % 4], "ar_count");
            cycle();
        end
        chk("ar_irq_set", {31'd0, irq}, 32'd1);
        wr(0, 32'hB, 4'hF);
        chk("ar_irq_clr", {31'd0, irq}, 32'd0);
        cycle();
        chk("ar_irq_again", {31'd0, irq}, 32'd1);

        // Byte-lane merge into PRESET.
        wr(1, 32'h1122_3344, 4'hF);
        wr(1, 32'hAABB_CCDD, 4'b0101);
        peek(1, 32'h11BB_33DD, "lane_merge");
        wr(0, 32'h0, 4'hF);
        repeat (2) cycle();

        // IM=0 hides the flag; a CTRL write clears it.
        wr(1, 32'd2, 4'hF);
        wr(0, 32'h1, 4'hF);
        repeat (6) cycle();
        chk("im0_irq", {31'd0, irq}, 32'd0);
        wr(0, 32'h8, 4'hF);
        chk("im1_after_clr", {31'd0, irq}, 32'd0);

        // COUNT offset is read-only; out-of-window accesses do nothing.
        wr(1, 32'd9, 4'hF);
        wr(0, 32'h1, 4'hF);
        repeat (4) cycle();
        peek(2, 32'd7, "cnt_before_wr");
        wr(2, 32'd3, 4'hF);
        peek(2, 32'd6, "cnt_wr_ignored");
        addr = BASE + 32'd16; wdata = 32'hFFFF_FFFF; byteen = 4'hF;
        #1;
        chk("miss_hit", {31'd0, hit}, 32'd0);
        chk("miss_rdata", rdata, 32'd0);
        cycle();
        bus_idle();
        peek(1, 32'd9, "miss_preset");

        // Clear EN so the engine stops with COUNT=4 held.
        run_until_count(32'd5, 1'b0, "wait_cnt5");
        wr(0, 32'h0, 4'hF);
        repeat (3) cycle();
        peek(2, 32'd4, "en_clr_hold");

        // Asynchronous reset mid-count, checked before any clock edge.
        wr(1, 32'd7, 4'hF);
        wr(0, 32'hB, 4'hF);
        run_until_count(32'd5, 1'b1, "wait_rst_point");
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        peek(2, 32'd0, "async_rst_count");
        peek(0, 32'd0, "async_rst_ctrl");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        bus_idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int op = $urandom_range(0, 9);
            if (op <= 3) begin
                addr   = BASE + 32'($urandom_range(0, 15));
                byteen = 4'd0;
                wdata  = $urandom;
            end else if (op <= 5) begin
                addr   = BASE + 32'($urandom_range(0, 3));
                byteen = 4'($urandom_range(1, 15));
                wdata  = {$urandom, 4'($urandom_range(0, 15) | ($urandom_range(0, 3) != 0 ? 1 : 0))};
            end else if (op <= 7) begin
                addr   = BASE + 32'd4;
                byteen = 4'($urandom_range(1, 15));
                wdata  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            end else if (op == 8) begin
                addr   = BASE + 32'(8 + $urandom_range(0, 7));
                byteen = 4'($urandom_range(1, 15));
                wdata  = $urandom;
            end else begin
                addr   = ($urandom_range(0, 1) == 0) ? BASE + 32'(16 + $urandom_range(0, 255)) : $urandom;
                byteen = 4'($urandom_range(0, 15));
                wdata  = $urandom;
            end
            cycle();
            if ($urandom_range(0, 2) == 0) begin
                bus_idle();
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
